// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its environment.
// Requester side: icache fetch (ic_*), load (ld_*), store (st_*) handshakes.
// Memory side: byte-wide RAM port (ram_*) plus the UART back-pressure flag io_full.
// master: the environment (requesters and RAM); slave: the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned LINE_BYTES = 16
);
    // icache fetch
    logic                    ic_req;
    logic [31:0]             ic_addr;
    logic                    ic_done;
    logic [8*LINE_BYTES-1:0] ic_line;
    // load
    logic                    ld_req;
    logic [31:0]             ld_addr;
    logic [2:0]              ld_len;
    logic                    ld_sext;
    logic                    ld_done;
    logic [31:0]             ld_data;
    // store
    logic                    st_req;
    logic [31:0]             st_addr;
    logic [2:0]              st_len;
    logic [31:0]             st_data;
    logic                    st_done;
    // RAM / UART
    logic                    io_full;
    logic                    ram_wr;
    logic [31:0]             ram_addr;
    logic [7:0]              ram_dout;
    logic [7:0]              ram_din;

    modport master (
        output ic_req, ic_addr, ld_req, ld_addr, ld_len, ld_sext,
               st_req, st_addr, st_len, st_data, io_full, ram_din,
        input  ic_done, ic_line, ld_done, ld_data, st_done,
               ram_wr, ram_addr, ram_dout
    );

    modport slave (
        input  ic_req, ic_addr, ld_req, ld_addr, ld_len, ld_sext,
               st_req, st_addr, st_len, st_data, io_full, ram_din,
        output ic_done, ic_line, ld_done, ld_data, st_done,
               ram_wr, ram_addr, ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: grants one of store > load > icache fetch from IDLE
// and moves the transfer one byte per cycle over a registered RAM port.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   rdy  - global ready; low freezes every register
//   rb   - rollback; cancels loads/fetches (never stores)
//   bus  - requester handshakes, RAM byte port and io_full (mem_arbiter_if.slave)
module mem_arbiter #(
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rb,
    mem_arbiter_if.slave bus
);
    localparam int unsigned OFF       = $clog2(LINE_BYTES);
    localparam int unsigned CW        = OFF + 1;
    localparam int unsigned LINE_BITS = 8 * LINE_BYTES;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic [1:0] {OP_ST, OP_LD, OP_IC} op_t;

    state_t               state, state_nxt;
    op_t                  op_q, op_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CW-1:0]        n_q, n_nxt;
    logic [31:0]          addr_q, addr_nxt;
    logic [31:0]          data_q, data_nxt;
    logic                 sext_q, sext_nxt;
    logic [LINE_BITS-1:0] line_q, line_nxt;

    logic                 ic_done_q, ic_done_nxt;
    logic                 ld_done_q, ld_done_nxt;
    logic                 st_done_q, st_done_nxt;
    logic                 ram_wr_q, ram_wr_nxt;
    logic [31:0]          ram_addr_q, ram_addr_nxt;
    logic [7:0]           ram_dout_q, ram_dout_nxt;
    logic [31:0]          ld_data_q, ld_data_nxt;
    logic [LINE_BITS-1:0] ic_line_q, ic_line_nxt;

    logic [OFF-1:0]       byte_idx;
    logic                 uart_c;

    // Unsupported lengths (0, 3, >4) collapse to a full word.
    function automatic logic [CW-1:0] len_dec(input logic [2:0] len);
        case (len)
            3'd1:    return CW'(1);
            3'd2:    return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [CW-1:0] n,
                                           input logic sext);
        if (n == CW'(1)) return sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
        if (n == CW'(2)) return sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
        return raw;
    endfunction

    // Next-state and registered-output values.
    always_comb begin
        state_nxt    = state;
        op_nxt       = op_q;
        cnt_nxt      = cnt;
        n_nxt        = n_q;
        addr_nxt     = addr_q;
        data_nxt     = data_q;
        sext_nxt     = sext_q;
        line_nxt     = line_q;
        ic_done_nxt  = 1'b0;
        ld_done_nxt  = 1'b0;
        st_done_nxt  = 1'b0;
        ram_wr_nxt   = 1'b0;
        ram_addr_nxt = 32'd0;
        ram_dout_nxt = 8'd0;
        ld_data_nxt  = ld_data_q;
        ic_line_nxt  = ic_line_q;
        byte_idx     = OFF'(cnt - CW'(1));
        uart_c       = (addr_q[17:16] == 2'b11);

        case (state)
            IDLE: begin
                if (bus.st_req) begin
                    state_nxt    = WRITE;
                    op_nxt       = OP_ST;
                    cnt_nxt      = '0;
                    addr_nxt     = bus.st_addr;
                    n_nxt        = len_dec(bus.st_len);
                    data_nxt     = bus.st_data;
                    ram_wr_nxt   = !((bus.st_addr[17:16] == 2'b11) && bus.io_full);
                    ram_addr_nxt = bus.st_addr;
                    ram_dout_nxt = bus.st_data[7:0];
                end else if (!rb && bus.ld_req) begin
                    state_nxt    = READ;
                    op_nxt       = OP_LD;
                    cnt_nxt      = '0;
                    addr_nxt     = bus.ld_addr;
                    n_nxt        = len_dec(bus.ld_len);
                    sext_nxt     = bus.ld_sext;
                    line_nxt     = '0;
                    ram_addr_nxt = bus.ld_addr;
                end else if (!rb && bus.ic_req) begin
                    state_nxt    = READ;
                    op_nxt       = OP_IC;
                    cnt_nxt      = '0;
                    addr_nxt     = bus.ic_addr & ~32'(LINE_BYTES - 1);
                    n_nxt        = CW'(LINE_BYTES);
                    line_nxt     = '0;
                    ram_addr_nxt = bus.ic_addr & ~32'(LINE_BYTES - 1);
                end
            end
            WRITE: begin
                // A byte counts as written only in a cycle where ram_wr was high.
                if (ram_wr_q && (cnt == n_q - CW'(1))) begin
                    state_nxt   = DONE;
                    cnt_nxt     = '0;
                    st_done_nxt = 1'b1;
                end else begin
                    if (ram_wr_q) cnt_nxt = cnt + CW'(1);
                    ram_wr_nxt   = !(uart_c && bus.io_full);
                    ram_addr_nxt = addr_q + 32'(cnt_nxt);
                    ram_dout_nxt = 8'(data_q >> {cnt_nxt[1:0], 3'b000});
                end
            end
            READ: begin
                if (rb) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // RAM returns the byte one cycle after its address.
                    if (cnt != '0) line_nxt[{byte_idx, 3'b000} +: 8] = bus.ram_din;
                    if (cnt == n_q) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                        if (op_q == OP_LD) begin
                            ld_done_nxt = 1'b1;
                            ld_data_nxt = extend(line_nxt[31:0], n_q, sext_q);
                        end else begin
                            ic_done_nxt = 1'b1;
                            ic_line_nxt = line_nxt;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        if (cnt_nxt != n_q) ram_addr_nxt = addr_q + 32'(cnt_nxt);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; rdy low holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= OP_ST;
            cnt        <= '0;
            n_q        <= '0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            sext_q     <= 1'b0;
            line_q     <= '0;
            ic_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= 32'd0;
            ram_dout_q <= 8'd0;
            ld_data_q  <= 32'd0;
            ic_line_q  <= '0;
        end else if (rdy) begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            cnt        <= cnt_nxt;
            n_q        <= n_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            sext_q     <= sext_nxt;
            line_q     <= line_nxt;
            ic_done_q  <= ic_done_nxt;
            ld_done_q  <= ld_done_nxt;
            st_done_q  <= st_done_nxt;
            ram_wr_q   <= ram_wr_nxt;
            ram_addr_q <= ram_addr_nxt;
            ram_dout_q <= ram_dout_nxt;
            ld_data_q  <= ld_data_nxt;
            ic_line_q  <= ic_line_nxt;
        end
    end

    assign bus.ic_done  = ic_done_q;
    assign bus.ic_line  = ic_line_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_data  = ld_data_q;
    assign bus.st_done  = st_done_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_dout = ram_dout_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, giving the icache line size in bytes (power of two, 4..64).
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: rdy  in  1  global ready; low freezes all state and holds registered outputs.
REQ-005 SHALL have ports: rb  in  1  rollback; cancels fetch and load traffic.
REQ-006 SHALL have ports: ic_req in 1; ic_addr in 32; ic_done out 1; ic_line out 8*LINE_BYTES, where byte i is at bits [8i+7:8i].
REQ-007 SHALL have ports: ld_req in 1; ld_addr in 32; ld_len in 3 (1/2/4 bytes); ld_sext in 1; ld_done out 1; ld_data out 32.
REQ-008 SHALL have ports: st_req in 1; st_addr in 32; st_len in 3 (1/2/4 bytes); st_data in 32; st_done out 1.
REQ-009 SHALL have ports: io_full in 1 (UART buffer full); ram_wr out 1 (1 = write); ram_addr out 32; ram_dout out 8; ram_din in 8.

Function
REQ-010 SHALL implement states IDLE, READ, WRITE and DONE, with a byte counter cnt of width log2(LINE_BYTES)+1.
REQ-011 SHALL sample requests only in IDLE, with fixed priority st > ld > ic and the grant taken on the edge that ends the IDLE cycle.
REQ-012 SHALL, in the cycle that rb is high, ignore ld_req and ic_req; a st_req in that cycle is still grantable.
REQ-013 SHALL register the requester's address, length and data at grant; requester inputs SHALL be don't-care after grant until its done pulse.
REQ-014 SHALL register all RAM outputs; cycle k is defined as the k-th cycle after the grant edge, starting from k = 0.
REQ-015 SHALL, for a store of length n, drive ram_wr=1, ram_addr=addr+k and ram_dout=data byte k (little-endian) in cycle k for k = 0..n-1, then enter DONE with st_done=1 for exactly one cycle.
REQ-016 SHALL handle the UART stall as follows: if addr[17:16]==2'b11 and io_full is high, WRITE holds with ram_wr=0 and cnt frozen, and the same byte is re-driven once io_full is low.
REQ-017 SHALL, for a read of n bytes, drive ram_wr=0 and ram_addr=addr+k in cycle k for k = 0..n-1, and capture ram_din in cycle k+1 as byte k.
REQ-018 SHALL produce ld_done=1 with ld_data valid for one cycle in cycle n+1 (DONE state); n=1 or n=2 with ld_sext set sign-extends from bit 8n-1, otherwise the result is zero-extended.
REQ-019 SHALL, for a fetch, force ic_addr low log2(LINE_BYTES) bits to zero and set n = LINE_BYTES; ic_done=1 with ic_line valid for one cycle in cycle LINE_BYTES+1.
REQ-020 SHALL, when rb is high during READ (load or fetch), return to IDLE on that edge with ram_wr=0 and ram_addr=0, emit no done pulse, and discard partial data.
REQ-021 SHALL leave WRITE and DONE-of-store unaffected by rb.
REQ-022 SHALL return from DONE to IDLE unconditionally, with no grant during DONE, giving a one-cycle turnaround.
REQ-023 SHALL drive ram_wr=0, ram_addr=0 and ram_dout=0 in IDLE and DONE.
REQ-024 SHALL keep ld_data and ic_line at their last values outside the done cycle.
REQ-025 SHALL compute address increments modulo 2^32 with no wrap check.
REQ-026 SHALL treat lengths 0, 3 and >4 as length 4.
REQ-027 SHALL ensure at most one done output is high in any cycle.

Reset
REQ-028 SHALL, while rst is low, asynchronously force: state=IDLE, cnt=0, all done outputs 0, ram_wr=0, ram_addr=0, ram_dout=0, ld_data=0, ic_line=0.
REQ-029 SHALL drop any in-flight transfer on reset without a done pulse, and begin arbitration on the first rdy-high edge after rst goes high.

Verification
REQ-030 SHALL be verified with a store test: st_addr=0x100, st_len=4, st_data=0x11223344 -> cycles 0-3 write 0x44, 0x33, 0x22, 0x11 to addresses 0x100-0x103, and st_done=1 in cycle 4.
REQ-031 SHALL be verified with a signed halfword load: ld_addr=0x20, ld_len=2, ld_sext=1, RAM bytes 0x80, 0xFF -> ld_done=1 in cycle 3 with ld_data=0xFFFFFF80; the same load with ld_sext=0 -> ld_data=0x0000FF80.
REQ-032 SHALL be verified with simultaneous requests: st, ld and ic all raised in the same IDLE cycle -> service order store, load, fetch, each separated by one DONE and one IDLE cycle.
REQ-033 SHALL be verified with rollback: rb pulsed in cycle 10 of a 16-byte fetch -> no ic_done pulse, ram_wr=0 and IDLE on the next cycle; a concurrent ld_req is not granted in the rb cycle.
REQ-034 SHALL be verified with a UART stall: a store of 0x41 to 0x30000 with io_full high for 5 cycles -> ram_wr stays 0 for those 5 cycles, then one write of 0x41, then st_done.
REQ-035 SHALL be verified with reset mid-store: rst low in cycle 2 of a 4-byte store -> outputs are 0 immediately, and no further write or st_done occurs.
